addr_unit: RTL and testbench
============================

Name: addr_unit

Overview:
- Registered successor to the CPU's combinational memory address mux.
- Latches low/high address bytes from the data bus and forms the bus address for every 6502 addressing mode: PC, zero page, zero page indexed, absolute, absolute indexed, stack, pointer-high and vector.
- Handles the indexed page-cross fix-up cycle, the forced dummy cycle on indexed writes, and the optional NMOS JMP-indirect page-wrap quirk.
- Sits between the control unit (mode, latch enables), the register file (index, SP) and the memory interface.

Parameters:
- DW, 8, data/byte width.
- AW, 16, address width; must equal 2*DW. Elaboration error otherwise.
- STACK_PAGE, 8'h01, high byte used for stack addresses.
- VEC_PAGE, 8'hFF, high byte used for vector fetches.
- NMOS_IND_BUG, 1, 1 = pointer-high address wraps within the page.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  advance enable; 0 freezes all internal state.
- mode  in  3  addressing mode: 0 PC, 1 ZP, 2 ZP_IDX, 3 ABS, 4 ABS_IDX, 5 STACK, 6 PTR_HI, 7 VECTOR.
- is_write  in  1  current access is a write (ABS_IDX only).
- pc_in  in  AW  program counter.
- data_in  in  DW  data bus read byte.
- lo_we  in  1  load ADL from data_in.
- hi_we  in  1  load ADH from data_in.
- idx_in  in  DW  X or Y index, selected by the control unit.
- sp_in  in  DW  stack pointer.
- addr_out  out  AW  memory address.
- stall  out  1  current cycle is a dummy access; the control unit must not advance its sequence.
- page_cross  out  1  indexed add carried out of the low byte in this cycle.

Behaviour:
- Reset (async assert, sync-safe release): ADL=0, ADH=0, state=IDLE, fix_hi=0, stall=0, page_cross=0. addr_out is then a pure function of mode and inputs (PC mode gives pc_in).
- Latches: on a rising edge with rdy=1, lo_we loads ADL and hi_we loads ADH. Both enables high loads both from the same byte. With rdy=0, nothing loads.
- sum = {1'b0,ADL} + idx_in, DW+1 bits; carry = sum[DW].
- addr_out in state IDLE, combinational, zero added latency:
  - PC: pc_in.
  - ZP: {0, ADL}.
  - ZP_IDX: {0, sum[DW-1:0]}; wraps within page 0, carry ignored, page_cross=0.
  - ABS: {ADH, ADL}.
  - ABS_IDX: {ADH, sum[DW-1:0]}; page_cross=carry.
  - STACK: {STACK_PAGE, sp_in}.
  - PTR_HI: NMOS_IND_BUG=1 gives {ADH, ADL+1} (low-byte wrap only). NMOS_IND_BUG=0 gives {ADH,ADL}+1 across the full AW bits.
  - VECTOR: {VEC_PAGE, ADL}.
- State machine (IDLE, FIX), transitions only when rdy=1:
  - IDLE → FIX when mode=ABS_IDX and (carry or is_write). In that same cycle stall=1, and fix_hi <= ADH + carry (mod 2^DW).
  - FIX: addr_out = {fix_hi, sum_lo_reg}, where sum_lo_reg is captured on entry. stall=0, page_cross=0. mode, ADL, ADH and idx_in are ignored for the address. Always returns to IDLE on the next rdy edge.
  - Latch enables remain active in FIX.
- Wrap-around: ADH=FF with carry gives fix_hi=00, i.e. the address wraps to page 0.
- rdy=0 in FIX: stays in FIX and keeps presenting the same address.
- rst_n asserted mid-FIX: returns to IDLE immediately and clears stall.
- stall and page_cross are combinational in IDLE and 0 in FIX.

Test Plan:
- Reset then mode=PC, pc_in=16'hC000 → addr_out=C000, stall=0, page_cross=0; ADL/ADH are 0, checked via mode=ABS → 0000.
- lo_we with data 34, then hi_we with data 12, mode=ABS → 1234. Next, lo_we and hi_we together with data 56 → 5656.
- ADL=F0, ADH=12, idx=20, ABS_IDX, read → cycle 1: addr 1210, stall=1, page_cross=1; cycle 2: addr 1310, stall=0; cycle 3: IDLE. With idx=05 → single cycle at 12F5, stall=0.
- ABS_IDX write, ADL=10, ADH=12, idx=05 → dummy cycle at 1215 with stall=1, then 1215 again with stall=0. ADH=FF, ADL=FF, idx=01 → FF00, then 0000.
- PTR_HI with ADL=FF, ADH=30: NMOS_IND_BUG=1 → 3000; NMOS_IND_BUG=0 → 3100. ZP_IDX with ADL=F0, idx=20 → 0010. STACK with sp=FD → 01FD. VECTOR with ADL=FC → FFFC.
- rdy=0 held 3 cycles in FIX → address and state hold. Pulse rst_n low mid-FIX → immediate IDLE, stall=0.

Source files
------------

// File: rtl/addr_unit_if.sv
// rtl/addr_unit_if.sv - control/register-file/memory-side bundle for addr_unit
interface addr_unit_if #(
  parameter int DW = 8,
  parameter int AW = 16
);
  logic          rdy;
  logic [2:0]    mode;
  logic          is_write;
  logic [AW-1:0] pc_in;
  logic [DW-1:0] data_in;
  logic          lo_we;
  logic          hi_we;
  logic [DW-1:0] idx_in;
  logic [DW-1:0] sp_in;
  logic [AW-1:0] addr_out;
  logic          stall;
  logic          page_cross;

  modport master (
    output rdy, mode, is_write, pc_in, data_in, lo_we, hi_we, idx_in, sp_in,
    input  addr_out, stall, page_cross
  );

  modport slave (
    input  rdy, mode, is_write, pc_in, data_in, lo_we, hi_we, idx_in, sp_in,
    output addr_out, stall, page_cross
  );
endinterface

// File: rtl/addr_unit.sv
// rtl/addr_unit.sv - registered 6502 address former with indexed page-cross fix-up
module addr_unit #(
  parameter int            DW           = 8,
  parameter int            AW           = 16,
  parameter logic [DW-1:0] STACK_PAGE   = 8'h01,
  parameter logic [DW-1:0] VEC_PAGE     = 8'hFF,
  parameter bit            NMOS_IND_BUG = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  addr_unit_if.slave bus
);

  generate
    if (AW != 2 * DW) begin : g_bad_aw
      $error("addr_unit: AW must equal 2*DW");
    end
  endgenerate

  localparam logic [2:0] M_PC      = 3'd0;
  localparam logic [2:0] M_ZP      = 3'd1;
  localparam logic [2:0] M_ZP_IDX  = 3'd2;
  localparam logic [2:0] M_ABS     = 3'd3;
  localparam logic [2:0] M_ABS_IDX = 3'd4;
  localparam logic [2:0] M_STACK   = 3'd5;
  localparam logic [2:0] M_PTR_HI  = 3'd6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FIX  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] adl_q, adl_d;
  logic [DW-1:0] adh_q, adh_d;
  logic [DW-1:0] fix_hi_q, fix_hi_d;
  logic [DW-1:0] sum_lo_q, sum_lo_d;

  logic [DW:0]   sum;
  logic          carry;
  logic [AW-1:0] ab;
  logic [AW-1:0] addr_c;
  logic          stall_c;
  logic          pcross_c;

  assign sum   = {1'b0, adl_q} + {1'b0, bus.idx_in};
  assign carry = sum[DW];
  assign ab    = {adh_q, adl_q};

  always_comb begin
    addr_c   = bus.pc_in;
    stall_c  = 1'b0;
    pcross_c = 1'b0;
    if (state_q == ST_FIX) begin
      addr_c = {fix_hi_q, sum_lo_q};
    end else begin
      case (bus.mode)
        M_PC:     addr_c = bus.pc_in;
        M_ZP:     addr_c = {{DW{1'b0}}, adl_q};
        M_ZP_IDX: addr_c = {{DW{1'b0}}, sum[DW-1:0]};
        M_ABS:    addr_c = ab;
        M_ABS_IDX: begin
          addr_c   = {adh_q, sum[DW-1:0]};
          pcross_c = carry;
          stall_c  = carry | bus.is_write;
        end
        M_STACK:  addr_c = {STACK_PAGE, bus.sp_in};
        M_PTR_HI: begin
          // NMOS parts never carry the pointer increment into the high byte
          if (NMOS_IND_BUG) addr_c = {adh_q, adl_q + {{(DW-1){1'b0}}, 1'b1}};
          else              addr_c = ab + {{(AW-1){1'b0}}, 1'b1};
        end
        default:  addr_c = {VEC_PAGE, adl_q};
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    adl_d    = adl_q;
    adh_d    = adh_q;
    fix_hi_d = fix_hi_q;
    sum_lo_d = sum_lo_q;
    if (bus.rdy) begin
      if (bus.lo_we) adl_d = bus.data_in;
      if (bus.hi_we) adh_d = bus.data_in;
      if (state_q == ST_FIX) begin
        state_d = ST_IDLE;
      end else if (bus.mode == M_ABS_IDX && (carry || bus.is_write)) begin
        state_d  = ST_FIX;
        fix_hi_d = adh_q + {{(DW-1){1'b0}}, carry};
        sum_lo_d = sum[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      adl_q    <= '0;
      adh_q    <= '0;
      fix_hi_q <= '0;
      sum_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      adl_q    <= adl_d;
      adh_q    <= adh_d;
      fix_hi_q <= fix_hi_d;
      sum_lo_q <= sum_lo_d;
    end
  end

  assign bus.addr_out   = addr_c;
  assign bus.stall      = stall_c;
  assign bus.page_cross = pcross_c;

endmodule

// File: tb/tb_addr_unit.sv
// tb/tb_addr_unit.sv - directed and randomized checks of addr_unit against a behavioural model
module tb_addr_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [2:0]  mode;
  logic        is_write;
  logic [15:0] pc_in;
  logic [7:0]  data_in;
  logic        lo_we;
  logic        hi_we;
  logic [7:0]  idx_in;
  logic [7:0]  sp_in;

  int checks = 0;
  int errors = 0;

  // behavioural model: the two latched bytes plus a pending fix-up address
  int m_adl, m_adh, m_fix_addr;
  bit m_fix;

  addr_unit_if #(.DW(8), .AW(16)) b1 ();
  addr_unit_if #(.DW(8), .AW(16)) b0 ();

  assign b1.rdy = rdy;       assign b0.rdy = rdy;
  assign b1.mode = mode;     assign b0.mode = mode;
  assign b1.is_write = is_write; assign b0.is_write = is_write;
  assign b1.pc_in = pc_in;   assign b0.pc_in = pc_in;
  assign b1.data_in = data_in; assign b0.data_in = data_in;
  assign b1.lo_we = lo_we;   assign b0.lo_we = lo_we;
  assign b1.hi_we = hi_we;   assign b0.hi_we = hi_we;
  assign b1.idx_in = idx_in; assign b0.idx_in = idx_in;
  assign b1.sp_in = sp_in;   assign b0.sp_in = sp_in;

  addr_unit #(.NMOS_IND_BUG(1'b1)) u_bug   (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  addr_unit #(.NMOS_IND_BUG(1'b0)) u_nobug (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit m_carry();
    return (m_adl + int'(idx_in)) > 255;
  endfunction

  function automatic logic [15:0] exp_addr(bit bug);
    int a;
    if (m_fix) return m_fix_addr[15:0];
    case (mode)
      3'd0: a = int'(pc_in);
      3'd1: a = m_adl;
      3'd2: a = (m_adl + int'(idx_in)) % 256;
      3'd3: a = m_adh * 256 + m_adl;
      3'd4: a = m_adh * 256 + (m_adl + int'(idx_in)) % 256;
      3'd5: a = 256 + int'(sp_in);
      3'd6: a = bug ? m_adh * 256 + (m_adl + 1) % 256 : (m_adh * 256 + m_adl + 1) % 65536;
      default: a = 255 * 256 + m_adl;
    endcase
    return a[15:0];
  endfunction

  function automatic logic exp_stall();
    return !m_fix && mode == 3'd4 && (m_carry() || is_write);
  endfunction

  function automatic logic exp_pcross();
    return !m_fix && mode == 3'd4 && m_carry();
  endfunction

  task automatic model_step();
    bit enter;
    int full;
    if (!rst_n || !rdy) return;
    enter = exp_stall();
    full  = (m_adh * 256 + m_adl + int'(idx_in)) % 65536;
    if (m_fix) m_fix = 1'b0;
    else if (enter) begin
      m_fix = 1'b1;
      m_fix_addr = full;
    end
    if (lo_we) m_adl = int'(data_in);
    if (hi_we) m_adh = int'(data_in);
  endtask

  task automatic model_reset();
    m_adl = 0; m_adh = 0; m_fix = 1'b0; m_fix_addr = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] lo, input logic [7:0] hi);
    mode = 3'd0; lo_we = 1'b1; data_in = lo; tick();
    lo_we = 1'b0; hi_we = 1'b1; data_in = hi; tick();
    hi_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; mode = 3'd0; is_write = 1'b0; pc_in = 16'hC000;
    data_in = 8'h00; lo_we = 1'b0; hi_we = 1'b0; idx_in = 8'h00; sp_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if ({b1.addr_out, b1.stall, b1.page_cross} !== {16'hC000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_pc: got %h/%b/%b want c000/0/0", b1.addr_out, b1.stall, b1.page_cross);
    end
    mode = 3'd3;
    #1;
    checks++;
    if (b1.addr_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_abs: got %h want 0000", b1.addr_out);
    end
    tick();
  endtask

  task automatic test_latches();
    mode = 3'd0; lo_we = 1'b1; data_in = 8'h34; tick();
    lo_we = 1'b0; hi_we = 1'b1; data_in = 8'h12; tick();
    hi_we = 1'b0; mode = 3'd3;
    #1;
    checks++;
    if (b1.addr_out !== 16'h1234) begin
      errors++;
      $display("FAIL latch_sep: got %h want 1234", b1.addr_out);
    end
    lo_we = 1'b1; hi_we = 1'b1; data_in = 8'h56; tick();
    lo_we = 1'b0; hi_we = 1'b0;
    #1;
    checks++;
    if (b1.addr_out !== 16'h5656) begin
      errors++;
      $display("FAIL latch_both: got %h want 5656", b1.addr_out);
    end
    rdy = 1'b0; lo_we = 1'b1; hi_we = 1'b1; data_in = 8'h99; tick();
    rdy = 1'b1; lo_we = 1'b0; hi_we = 1'b0;
    #1;
    checks++;
    if (b1.addr_out !== 16'h5656) begin
      errors++;
      $display("FAIL latch_rdy0: got %h want 5656", b1.addr_out);
    end
    tick();
  endtask

  task automatic test_abs_idx_read();
    load(8'hF0, 8'h12);
    mode = 3'd4; idx_in = 8'h20; is_write = 1'b0;
    #1;
    checks++;
    if ({b1.addr_out, b1.stall, b1.page_cross} !== {16'h1210, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rd_cross_c1: got %h/%b/%b want 1210/1/1", b1.addr_out, b1.stall, b1.page_cross);
    end
    tick();
    checks++;
    if ({b1.addr_out, b1.stall, b1.page_cross} !== {16'h1310, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rd_cross_c2: got %h/%b/%b want 1310/0/0", b1.addr_out, b1.stall, b1.page_cross);
    end
    tick();
    mode = 3'd3;
    #1;
    checks++;
    if (b1.addr_out !== 16'h12F0) begin
      errors++;
      $display("FAIL rd_cross_c3_idle: got %h want 12f0", b1.addr_out);
    end
    mode = 3'd4; idx_in = 8'h05;
    #1;
    checks++;
    if ({b1.addr_out, b1.stall, b1.page_cross} !== {16'h12F5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rd_nocross: got %h/%b/%b want 12f5/0/0", b1.addr_out, b1.stall, b1.page_cross);
    end
    tick();
    checks++;
    if ({b1.addr_out, b1.stall} !== {16'h12F5, 1'b0}) begin
      errors++;
      $display("FAIL rd_nocross_next: got %h/%b want 12f5/0", b1.addr_out, b1.stall);
    end
    mode = 3'd0;
    tick();
  endtask

  task automatic test_abs_idx_write();
    load(8'h10, 8'h12);
    mode = 3'd4; idx_in = 8'h05; is_write = 1'b1;
    #1;
    checks++;
    if ({b1.addr_out, b1.stall, b1.page_cross} !== {16'h1215, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wr_dummy: got %h/%b/%b want 1215/1/0", b1.addr_out, b1.stall, b1.page_cross);
    end
    tick();
    checks++;
    if ({b1.addr_out, b1.stall} !== {16'h1215, 1'b0}) begin
      errors++;
      $display("FAIL wr_real: got %h/%b want 1215/0", b1.addr_out, b1.stall);
    end
    tick();
    is_write = 1'b0;
    load(8'hFF, 8'hFF);
    mode = 3'd4; idx_in = 8'h01; is_write = 1'b1;
    #1;
    checks++;
    if ({b1.addr_out, b1.stall, b1.page_cross} !== {16'hFF00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wr_wrap_c1: got %h/%b/%b want ff00/1/1", b1.addr_out, b1.stall, b1.page_cross);
    end
    tick();
    checks++;
    if ({b1.addr_out, b1.stall, b1.page_cross} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wr_wrap_c2: got %h/%b/%b want 0000/0/0", b1.addr_out, b1.stall, b1.page_cross);
    end
    tick();
    is_write = 1'b0; mode = 3'd0;
    tick();
  endtask

  task automatic test_modes();
    load(8'hFF, 8'h30);
    mode = 3'd6;
    #1;
    checks++;
    if (b1.addr_out !== 16'h3000) begin
      errors++;
      $display("FAIL ptr_hi_nmos: got %h want 3000", b1.addr_out);
    end
    checks++;
    if (b0.addr_out !== 16'h3100) begin
      errors++;
      $display("FAIL ptr_hi_fixed: got %h want 3100", b0.addr_out);
    end
    load(8'hF0, 8'h30);
    mode = 3'd2; idx_in = 8'h20;
    #1;
    checks++;
    if ({b1.addr_out, b1.stall, b1.page_cross} !== {16'h0010, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL zp_idx_wrap: got %h/%b/%b want 0010/0/0", b1.addr_out, b1.stall, b1.page_cross);
    end
    mode = 3'd5; sp_in = 8'hFD;
    #1;
    checks++;
    if (b1.addr_out !== 16'h01FD) begin
      errors++;
      $display("FAIL stack: got %h want 01fd", b1.addr_out);
    end
    load(8'hFC, 8'h30);
    mode = 3'd7;
    #1;
    checks++;
    if (b1.addr_out !== 16'hFFFC) begin
      errors++;
      $display("FAIL vector: got %h want fffc", b1.addr_out);
    end
    mode = 3'd1;
    #1;
    checks++;
    if (b1.addr_out !== 16'h00FC) begin
      errors++;
      $display("FAIL zp: got %h want 00fc", b1.addr_out);
    end
    tick();
  endtask

  task automatic test_rdy_hold();
    load(8'hF0, 8'h12);
    mode = 3'd4; idx_in = 8'h20; is_write = 1'b0; pc_in = 16'hBEEF;
    tick();
    rdy = 1'b0; mode = 3'd0; idx_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({b1.addr_out, b1.stall, b1.page_cross} !== {16'h1310, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rdy_hold_%0d: got %h/%b/%b want 1310/0/0", i, b1.addr_out, b1.stall, b1.page_cross);
      end
      tick();
    end
    rdy = 1'b1;
    #1;
    checks++;
    if (b1.addr_out !== 16'h1310) begin
      errors++;
      $display("FAIL rdy_resume_fix: got %h want 1310", b1.addr_out);
    end
    tick();
    checks++;
    if (b1.addr_out !== 16'hBEEF) begin
      errors++;
      $display("FAIL rdy_resume_idle: got %h want beef", b1.addr_out);
    end
    tick();
  endtask

  task automatic test_reset_mid_fix();
    load(8'hF0, 8'h12);
    mode = 3'd4; idx_in = 8'h20; is_write = 1'b0;
    tick();
    #1;
    checks++;
    if (b1.addr_out !== 16'h1310) begin
      errors++;
      $display("FAIL rst_fix_pre: got %h want 1310", b1.addr_out);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({b1.addr_out, b1.stall, b1.page_cross} !== {16'h0020, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_fix_idle: got %h/%b/%b want 0020/0/0", b1.addr_out, b1.stall, b1.page_cross);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 3'd0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rdy      = ($urandom_range(0, 4) != 0);
      mode     = 3'($urandom_range(0, 7));
      is_write = 1'($urandom_range(0, 1));
      pc_in    = 16'($urandom);
      data_in  = 8'($urandom);
      lo_we    = 1'($urandom_range(0, 1));
      hi_we    = 1'($urandom_range(0, 1));
      idx_in   = 8'($urandom);
      sp_in    = 8'($urandom);
      #1;
      checks++;
      if ({b1.addr_out, b1.stall, b1.page_cross} !== {exp_addr(1'b1), exp_stall(), exp_pcross()}) begin
        errors++;
        $display("FAIL rand_%0d nmos: got %h/%b/%b want %h/%b/%b", n, b1.addr_out, b1.stall,
                 b1.page_cross, exp_addr(1'b1), exp_stall(), exp_pcross());
      end
      checks++;
      if (b0.addr_out !== exp_addr(1'b0)) begin
        errors++;
        $display("FAIL rand_%0d fixed: got %h want %h", n, b0.addr_out, exp_addr(1'b0));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_latches();
    test_abs_idx_read();
    test_abs_idx_write();
    test_modes();
    test_rdy_hold();
    test_reset_mid_fix();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
